// File: rtl/kyber_bram_port_arbiter.sv
// kyber_bram_port_arbiter
// -----------------------
// Lets NUM_CH Kyber-side clients (NTT, sampler, pack/unpack, ...) share one
// wide BRAM port B. There is one access per cycle. The request is chosen by
// round-robin (ARB_MODE=0) or fixed priority with channel 0 highest
// (ARB_MODE=1). The chosen request is registered onto the BRAM pins, and read
// data is routed back to the requesting channel after RD_LAT cycles.
//
// Handshake: ch_en[i] is a level request that the client holds until it sees
// ch_gnt[i]=1. The request is consumed on the rising edge that ends the
// cycle in which ch_gnt[i] is high. There is no backpressure on returns:
// ch_rvalid[i] is a single-cycle strobe, and ch_rddata is only meaningful
// while some ch_rvalid bit is set.
//
// Ports:
//   reg_clk, reg_rst     clock, synchronous active-high reset
//   ch_en[NUM_CH]        per-channel request
//   ch_we                per-channel byte enables (all zero = read)
//   ch_addr, ch_wrdata   per-channel address / write data, channel i at slice i
//   ch_gnt               one-hot grant (combinational)
//   ch_rvalid            one-hot read-return strobe
//   ch_rddata            read data broadcast to all channels
//   en_br, we_br,        registered BRAM port B controls
//   addr_br, wrdata_br
//   rddata_br            BRAM port B read data
module kyber_bram_port_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                       reg_clk,
  input  logic                       reg_rst,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wrdata,
  output logic [NUM_CH-1:0]          ch_gnt,
  output logic [NUM_CH-1:0]          ch_rvalid,
  output logic [DATA_W-1:0]          ch_rddata,
  output logic                       en_br,
  output logic [DATA_W/8-1:0]        we_br,
  output logic [ADDR_W-1:0]          addr_br,
  output logic [DATA_W-1:0]          wrdata_br,
  input  logic [DATA_W-1:0]          rddata_br
);

  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PIPE_D = 1 + RD_LAT;

  // Round-robin pointer: index of the last granted channel.
  logic [IDX_W-1:0] ptr;

  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W:0]   rr_sum;
  logic [IDX_W-1:0] rr_cand;

  // Selected channel's request fields
  logic [BE_W-1:0]   we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wrdata_sel;

  // Return tag pipeline: stage k holds the tag of the access granted k+1 cycles ago
  logic [PIPE_D-1:0] tag_v;
  logic [IDX_W-1:0]  tag_idx [PIPE_D];

  // ---------------------------------------------------------------------------
  // Arbitration (combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_cand = '0;
    if (!reg_rst) begin
      if (ARB_MODE == 1) begin
        // Walk from the top down so the lowest requesting index is the last write.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (ch_en[i]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(i);
          end
        end
      end else begin
        // Candidate k is (ptr+k) mod NUM_CH. Walk k from NUM_CH down to 1 so
        // that the first candidate in search order is the last write.
        // ptr+k < 2*NUM_CH, so one conditional subtract is enough for the modulo.
        for (int k = NUM_CH; k >= 1; k--) begin
          rr_sum  = {1'b0, ptr} + (IDX_W+1)'(k);
          rr_cand = (rr_sum >= (IDX_W+1)'(NUM_CH)) ?
                    IDX_W'(rr_sum - (IDX_W+1)'(NUM_CH)) : IDX_W'(rr_sum);
          if (ch_en[rr_cand]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_cand;
          end
        end
      end
    end
  end

  assign ch_gnt = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;

  // Mux of the granted channel's slices
  always_comb begin
    we_sel     = '0;
    addr_sel   = '0;
    wrdata_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        we_sel     = ch_we[i*BE_W +: BE_W];
        addr_sel   = ch_addr[i*ADDR_W +: ADDR_W];
        wrdata_sel = ch_wrdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and registered issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      ptr <= IDX_W'(NUM_CH - 1);
    end else if (ARB_MODE == 0 && gnt_any) begin
      ptr <= gnt_idx;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      en_br     <= 1'b0;
      we_br     <= '0;
      addr_br   <= '0;
      wrdata_br <= '0;
    end else if (gnt_any) begin
      en_br     <= 1'b1;
      we_br     <= we_sel;
      addr_br   <= addr_sel;
      wrdata_br <= wrdata_sel;
    end else begin
      // Address and data hold on idle cycles; only the strobes drop.
      en_br <= 1'b0;
      we_br <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return routing
  // ---------------------------------------------------------------------------
  // Only reads push a valid tag, so writes never produce a return strobe.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      tag_v <= '0;
      for (int k = 0; k < PIPE_D; k++) tag_idx[k] <= '0;
    end else begin
      tag_v      <= {tag_v[PIPE_D-2:0], gnt_any && (we_sel == '0)};
      tag_idx[0] <= gnt_idx;
      for (int k = 1; k < PIPE_D; k++) tag_idx[k] <= tag_idx[k-1];
    end
  end

  // The last stage lines up with BRAM output data (issue cycle + RD_LAT).
  assign ch_rvalid = tag_v[PIPE_D-1] ? (NUM_CH'(1) << tag_idx[PIPE_D-1]) : '0;
  assign ch_rddata = rddata_br;

endmodule

// File: tb/tb_kyber_bram_port_arbiter.sv
// Bench for kyber_bram_port_arbiter. It runs three instances in parallel on
// the same channel stimulus:
//   a: round robin, RD_LAT=1
//   b: fixed priority, RD_LAT=1
//   c: round robin, RD_LAT=2
// Each instance has its own behavioural BRAM. Inputs are driven at the
// negedge, and outputs are sampled 1 time unit later.
module tb_kyber_bram_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   ch_en;
  logic [31:0]  ch_we;
  logic [15:0]  ch_addr;
  logic [255:0] ch_wrdata;

  logic [1:0]   gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
  logic [127:0] rd_a, rd_b, rd_c, wd_a, wd_b, wd_c, rdbr_a, rdbr_b, rdbr_c, rdq_c;
  logic         en_a, en_b, en_c;
  logic [15:0]  we_a, we_b, we_c;
  logic [7:0]   addr_a, addr_b, addr_c;

  logic [127:0] mem_a [256];
  logic [127:0] mem_b [256];
  logic [127:0] mem_c [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kyber_bram_port_arbiter #(.NUM_CH(2), .DATA_W(128), .ADDR_W(8), .RD_LAT(1), .ARB_MODE(0)) dut_a (
    .reg_clk(clk), .reg_rst(rst), .ch_en(ch_en), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_gnt(gnt_a), .ch_rvalid(rv_a), .ch_rddata(rd_a),
    .en_br(en_a), .we_br(we_a), .addr_br(addr_a), .wrdata_br(wd_a), .rddata_br(rdbr_a));

  kyber_bram_port_arbiter #(.NUM_CH(2), .DATA_W(128), .ADDR_W(8), .RD_LAT(1), .ARB_MODE(1)) dut_b (
    .reg_clk(clk), .reg_rst(rst), .ch_en(ch_en), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_gnt(gnt_b), .ch_rvalid(rv_b), .ch_rddata(rd_b),
    .en_br(en_b), .we_br(we_b), .addr_br(addr_b), .wrdata_br(wd_b), .rddata_br(rdbr_b));

  kyber_bram_port_arbiter #(.NUM_CH(2), .DATA_W(128), .ADDR_W(8), .RD_LAT(2), .ARB_MODE(0)) dut_c (
    .reg_clk(clk), .reg_rst(rst), .ch_en(ch_en), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wrdata(ch_wrdata), .ch_gnt(gnt_c), .ch_rvalid(rv_c), .ch_rddata(rd_c),
    .en_br(en_c), .we_br(we_c), .addr_br(addr_c), .wrdata_br(wd_c), .rddata_br(rdbr_c));

  // Behavioural BRAMs: byte-enable write, read-first, latency 1 (a, b) or 2 (c)
  always @(posedge clk) begin
    if (en_a) begin
      for (int b = 0; b < 16; b++) if (we_a[b]) mem_a[addr_a][b*8 +: 8] <= wd_a[b*8 +: 8];
      rdbr_a <= mem_a[addr_a];
    end
    if (en_b) begin
      for (int b = 0; b < 16; b++) if (we_b[b]) mem_b[addr_b][b*8 +: 8] <= wd_b[b*8 +: 8];
      rdbr_b <= mem_b[addr_b];
    end
    if (en_c) begin
      for (int b = 0; b < 16; b++) if (we_c[b]) mem_c[addr_c][b*8 +: 8] <= wd_c[b*8 +: 8];
      rdq_c <= mem_c[addr_c];
    end
    rdbr_c <= rdq_c;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] en;
    logic [1:0] gnt_rr;
    logic [1:0] gnt_fp;
    logic [1:0] rv_rr;
  } vec_t;

  vec_t tbl [12];

  localparam logic [127:0] WR = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] W1 = 128'hDEADBEEFCAFEF00D5555AAAA12345678;
  logic [127:0] dpat [3];

  initial begin
    // Channel-contention vectors. The RR pointer starts at 1 because the last
    // grant before this table went to ch1. rv_rr is the grant from two rows
    // earlier, restricted to reads (all rows here are reads).
    tbl[0]  = '{2'b11, 2'b01, 2'b01, 2'b00};
    tbl[1]  = '{2'b11, 2'b10, 2'b01, 2'b00};
    tbl[2]  = '{2'b11, 2'b01, 2'b01, 2'b01};
    tbl[3]  = '{2'b11, 2'b10, 2'b01, 2'b10};
    tbl[4]  = '{2'b11, 2'b01, 2'b01, 2'b01};
    tbl[5]  = '{2'b11, 2'b10, 2'b01, 2'b10};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 2'b01};
    tbl[7]  = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[8]  = '{2'b11, 2'b01, 2'b01, 2'b00};
    tbl[9]  = '{2'b01, 2'b01, 2'b01, 2'b10};
    tbl[10] = '{2'b11, 2'b10, 2'b01, 2'b01};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 2'b01};
    dpat[0] = {16{8'hA0}};
    dpat[1] = {16{8'hB1}};
    dpat[2] = {16{8'hC2}};

    rst = 1'b1; ch_en = '0; ch_we = '0; ch_addr = '0; ch_wrdata = '0;

    // ---- reset: grant forced low while reset is high ----
    @(negedge clk);
    ch_en = 2'b11;
    #1 chk("gnt_in_reset_rr", gnt_a, 2'b00);
    chk("gnt_in_reset_fp", gnt_b, 2'b00);
    @(negedge clk);
    rst = 1'b0; ch_en = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1 chk("idle_gnt", gnt_a, 2'b00);
      chk("idle_rvalid", rv_a, 2'b00);
      chk("idle_en_br", en_a, 1'b0);
      chk("idle_we_br", we_a, 16'h0);
      chk("idle_addr_br", addr_a, 8'h0);
      chk("idle_wrdata_br", wd_a, 128'h0);
      @(negedge clk);
    end

    // ---- ch0 full write to 0x10, then ch1 read of 0x10 ----
    ch_en = 2'b01; ch_we = {16'h0000, 16'hFFFF}; ch_addr = {8'h10, 8'h10}; ch_wrdata = {W1, WR};
    #1 chk("wr_gnt_rr", gnt_a, 2'b01);
    chk("wr_gnt_fp", gnt_b, 2'b01);
    @(negedge clk);
    ch_en = 2'b10; ch_we = 32'h0;
    #1 chk("rd_gnt_rr", gnt_a, 2'b10);
    chk("rd_gnt_lat2", gnt_c, 2'b10);
    chk("wr_issue_en", en_a, 1'b1);
    chk("wr_issue_we", we_a, 16'hFFFF);
    chk("wr_issue_addr", addr_a, 8'h10);
    chk("wr_issue_data", wd_a, WR);
    @(negedge clk);
    ch_en = 2'b00;
    #1 chk("rd_issue_gnt", gnt_a, 2'b00);
    chk("rd_issue_en", en_a, 1'b1);
    chk("rd_issue_we", we_a, 16'h0);
    chk("rd_issue_data", wd_a, W1);
    chk("no_rvalid_for_write", rv_a, 2'b00);
    @(negedge clk);
    #1 chk("idle_en_drop", en_a, 1'b0);
    chk("idle_addr_hold", addr_a, 8'h10);
    chk("idle_data_hold", wd_a, W1);
    chk("rd_ret_rvalid", rv_a, 2'b10);
    chk("rd_ret_data", rd_a, WR);
    chk("rd_ret_rvalid_fp", rv_b, 2'b10);
    chk("rd_ret_lat2_early", rv_c, 2'b00);
    @(negedge clk);
    #1 chk("rd_ret_rvalid_done", rv_a, 2'b00);
    chk("rd_ret_lat2_rvalid", rv_c, 2'b10);
    chk("rd_ret_lat2_data", rd_c, WR);
    @(negedge clk);
    #1 chk("rd_ret_lat2_done", rv_c, 2'b00);
    @(negedge clk);

    // ---- contention table: RR alternation vs fixed priority ----
    for (int r = 0; r < 12; r++) begin
      ch_en = tbl[r].en; ch_we = 32'h0;
      ch_addr = {8'(8'h40 + r), 8'(8'h30 + r)};
      #1 chk($sformatf("tbl%0d_gnt_rr", r), gnt_a, tbl[r].gnt_rr);
      chk($sformatf("tbl%0d_gnt_fp", r), gnt_b, tbl[r].gnt_fp);
      chk($sformatf("tbl%0d_rvalid_rr", r), rv_a, tbl[r].rv_rr);
      @(negedge clk);
    end
    ch_en = 2'b00;
    repeat (4) @(negedge clk);

    // ---- RD_LAT=2 back-to-back reads from ch1 (after writing 0..2) ----
    for (int k = 0; k < 3; k++) begin
      ch_en = 2'b10; ch_we = {16'hFFFF, 16'h0000};
      ch_addr = {8'(k), 8'h00}; ch_wrdata = {dpat[k], 128'h0};
      #1 chk($sformatf("seq_wr%0d_gnt", k), gnt_a, 2'b10);
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        ch_en = 2'b10; ch_we = 32'h0; ch_addr = {8'(c), 8'h00};
      end else begin
        ch_en = 2'b00;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("seq_c%0d_rvalid_lat1", c), rv_a, 2'b10);
        chk($sformatf("seq_c%0d_data_lat1", c), rd_a, dpat[c-2]);
      end else begin
        chk($sformatf("seq_c%0d_rvalid_lat1", c), rv_a, 2'b00);
      end
      if (c >= 3 && c <= 5) begin
        chk($sformatf("seq_c%0d_rvalid_lat2", c), rv_c, 2'b10);
        chk($sformatf("seq_c%0d_data_lat2", c), rd_c, dpat[c-3]);
      end else begin
        chk($sformatf("seq_c%0d_rvalid_lat2", c), rv_c, 2'b00);
      end
      @(negedge clk);
    end

    // ---- reset one cycle after a ch0 read grant ----
    ch_en = 2'b01; ch_we = 32'h0; ch_addr = {8'h00, 8'h10};
    #1 chk("rst_seq_gnt", gnt_a, 2'b01);
    @(negedge clk);
    rst = 1'b1; ch_en = 2'b11;
    #1 chk("rst_seq_gnt_forced", gnt_a, 2'b00);
    chk("rst_seq_issued", en_a, 1'b1);
    @(negedge clk);
    rst = 1'b0; ch_en = 2'b11;
    #1 chk("rst_seq_ptr_gnt_rr", gnt_a, 2'b01);
    chk("rst_seq_ptr_gnt_fp", gnt_b, 2'b01);
    chk("rst_seq_en_cleared", en_a, 1'b0);
    chk("rst_seq_no_rv_lat1", rv_a, 2'b00);
    chk("rst_seq_no_rv_lat2", rv_c, 2'b00);
    @(negedge clk);
    ch_en = 2'b00;
    #1 chk("rst_seq_no_rv_lat1_b", rv_a, 2'b00);
    chk("rst_seq_no_rv_lat2_b", rv_c, 2'b00);
    @(negedge clk);
    #1 chk("rst_seq_new_rv_lat1", rv_a, 2'b01);
    chk("rst_seq_new_data_lat1", rd_a, WR);
    chk("rst_seq_no_rv_lat2_c", rv_c, 2'b00);
    @(negedge clk);
    #1 chk("rst_seq_new_rv_lat2", rv_c, 2'b01);
    chk("rst_seq_new_data_lat2", rd_c, WR);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
